// File: rtl/culsans_exit_pkg.sv
// Shared types for the Culsans end-of-test monitor: FSM state encoding,
// tohost-format exit word and the code-extraction helper.
package culsans_exit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } exit_state_e;

  localparam int unsigned DefaultExitWidth = 32;

  typedef logic [DefaultExitWidth-1:0] exit_word_t;

  // tohost format: bit 0 is the valid flag, the rest is the return code.
  function automatic exit_word_t exit_code(input exit_word_t word);
    return word >> 1;
  endfunction

endpackage

// File: rtl/culsans_exit_latch.sv
// One exit channel: captures the first valid tohost report while enabled and
// holds it. The *_nxt outputs show post-edge state so the top can finish on the capturing edge.
module culsans_exit_latch #(
  parameter int unsigned ExitWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture_i,
  input  logic [ExitWidth-1:0] exit_i,
  output logic                 exited_o,
  output logic                 fail_o,
  output logic                 exited_nxt_o,
  output logic                 fail_nxt_o,
  output logic [ExitWidth-2:0] code_nxt_o
);

  logic                 exited_q, exited_d;
  logic [ExitWidth-2:0] code_q, code_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    exited_d = exited_q;
    code_d   = code_q;
    if (capture_i && !exited_q && exit_i[0]) begin
      exited_d = 1'b1;
      code_d   = exit_i[ExitWidth-1:1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exited_q <= 1'b0;
      code_q   <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values.
      exited_q <= exited_d;
      code_q   <= code_d;
    end
  end

  assign exited_o     = exited_q;
  assign fail_o       = |code_q;
  assign exited_nxt_o = exited_d;
  assign fail_nxt_o   = |code_d;
  assign code_nxt_o   = code_d;

endmodule

// File: rtl/culsans_exit_monitor.sv
// Multi-channel end-of-test monitor: IDLE -> RUN -> DONE, aggregating per-core
// exit reports into one done/pass verdict with a run-time watchdog.
module culsans_exit_monitor
  import culsans_exit_pkg::*;
#(
  parameter int unsigned NumChannels   = 2,
  parameter int unsigned ExitWidth     = 32,
  parameter int unsigned CntWidth      = 32,
  parameter int unsigned TimeoutCycles = 1_000_000,
  parameter bit          WaitAll       = 1'b1,
  parameter bit          FailFast      = 1'b1,
  localparam int unsigned IdxWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [NumChannels-1:0][ExitWidth-1:0] exit_i,
  output logic [NumChannels-1:0]                exited_o,
  output logic                                  done_o,
  output logic                                  pass_o,
  output logic                                  timeout_o,
  output logic [ExitWidth-2:0]                  code_o,
  output logic [IdxWidth-1:0]                   code_idx_o,
  output logic [CntWidth-1:0]                   cycles_o
);

  localparam logic [CntWidth-1:0] TimeoutLast =
    CntWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  exit_state_e          state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 code_set_q, code_set_d;
  logic [ExitWidth-2:0] code_q, code_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;

  logic                                  run_active;
  logic [NumChannels-1:0]                exited_q, fail_q, exited_nxt, fail_nxt;
  logic [NumChannels-1:0][ExitWidth-2:0] code_nxt;

  assign run_active = (state_q == RUN);

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    culsans_exit_latch #(
      .ExitWidth(ExitWidth)
    ) u_latch (
      .clk          (clk),
      .rst          (rst),
      .capture_i    (run_active),
      .exit_i       (exit_i[c]),
      .exited_o     (exited_q[c]),
      .fail_o       (fail_q[c]),
      .exited_nxt_o (exited_nxt[c]),
      .fail_nxt_o   (fail_nxt[c]),
      .code_nxt_o   (code_nxt[c])
    );
  end

  // Lowest-index failing channel wins; scanning downward lets it overwrite higher ones.
  logic [ExitWidth-2:0] sel_code;
  logic [IdxWidth-1:0]  sel_idx;

  always_comb begin
    sel_code = '0;
    sel_idx  = '0;
    for (int c = int'(NumChannels) - 1; c >= 0; c--) begin
      if (fail_nxt[c]) begin
        sel_code = code_nxt[c];
        sel_idx  = IdxWidth'(c);
      end
    end
  end

  logic complete, watchdog_hit;

  assign complete     = (WaitAll ? (&exited_nxt) : (|exited_nxt)) || (FailFast && (|fail_nxt));
  assign watchdog_hit = (TimeoutCycles != 0) && (cnt_q == TimeoutLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    code_set_d = code_set_q;
    code_d     = code_q;
    idx_d      = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (!code_set_q && (|fail_nxt)) begin
          code_set_d = 1'b1;
          code_d     = sel_code;
          idx_d      = sel_idx;
        end
        // Completion takes priority over a coincident watchdog expiry.
        if (complete) begin
          state_d = DONE;
        end else if (watchdog_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      code_set_q <= 1'b0;
      code_q     <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      code_set_q <= code_set_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
    end
  end

  assign exited_o   = exited_q;
  assign done_o     = (state_q == DONE);
  assign pass_o     = done_o && !timeout_q && !(|fail_q);
  assign timeout_o  = timeout_q;
  assign code_o     = code_q;
  assign code_idx_o = idx_q;
  assign cycles_o   = cnt_q;

endmodule

// File: tb/tb_culsans_exit_monitor.sv
// Directed bench for culsans_exit_monitor: three configurations share one
// stimulus stream, and each scenario checks the instance it targets.
module tb_culsans_exit_monitor;

  localparam int NCH = 2;
  localparam int EW  = 32;
  localparam int CW  = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic [NCH-1:0][EW-1:0]  exit_v = '0;

  // a: WaitAll=1 FailFast=1 T=100, b: WaitAll=1 FailFast=0 T=10, c: WaitAll=0 FailFast=1 T=100
  logic [NCH-1:0] exited_a, exited_b, exited_c;
  logic           done_a, done_b, done_c;
  logic           pass_a, pass_b, pass_c;
  logic           tmo_a, tmo_b, tmo_c;
  logic [EW-2:0]  code_a, code_b, code_c;
  logic [0:0]     idx_a, idx_b, idx_c;
  logic [CW-1:0]  cyc_a, cyc_b, cyc_c;

  int vec_cnt = 0;
  int err_cnt = 0;
  int edge_n  = 0;

  always #5 clk = ~clk;

  culsans_exit_monitor #(.NumChannels(NCH), .ExitWidth(EW), .CntWidth(CW),
    .TimeoutCycles(100), .WaitAll(1'b1), .FailFast(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start_i(start), .exit_i(exit_v),
    .exited_o(exited_a), .done_o(done_a), .pass_o(pass_a), .timeout_o(tmo_a),
    .code_o(code_a), .code_idx_o(idx_a), .cycles_o(cyc_a));

  culsans_exit_monitor #(.NumChannels(NCH), .ExitWidth(EW), .CntWidth(CW),
    .TimeoutCycles(10), .WaitAll(1'b1), .FailFast(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start_i(start), .exit_i(exit_v),
    .exited_o(exited_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(tmo_b),
    .code_o(code_b), .code_idx_o(idx_b), .cycles_o(cyc_b));

  culsans_exit_monitor #(.NumChannels(NCH), .ExitWidth(EW), .CntWidth(CW),
    .TimeoutCycles(100), .WaitAll(1'b0), .FailFast(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start_i(start), .exit_i(exit_v),
    .exited_o(exited_c), .done_o(done_c), .pass_o(pass_c), .timeout_o(tmo_c),
    .code_o(code_c), .code_idx_o(idx_c), .cycles_o(cyc_c));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    start  = 1'b0;
    exit_v = '0;
    rst    = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    edge_n = 0;
  endtask

  // Start edge is IDLE->RUN; RUN edges are then numbered from 1.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    edge_n = 0;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_exited", 32'(exited_a), 32'h0);
    check("rst_done",   32'(done_a),   32'h0);
    check("rst_pass",   32'(pass_a),   32'h0);
    check("rst_tmo",    32'(tmo_a),    32'h0);
    check("rst_code",   32'(code_a),   32'h0);
    check("rst_idx",    32'(idx_a),    32'h0);
    check("rst_cycles", cyc_a,         32'h0);

    // Both channels pass: ch0 at edge 5, ch1 at edge 9
    do_start();
    run_to(4);
    exit_v[0] = 32'h1;
    run_to(8);
    check("t1_e8_done",   32'(done_a),   32'h0);
    check("t1_e8_exited", 32'(exited_a), 32'h1);
    exit_v[1] = 32'h1;
    run_to(9);
    check("t1_done",   32'(done_a),   32'h1);
    check("t1_pass",   32'(pass_a),   32'h1);
    check("t1_code",   32'(code_a),   32'h0);
    check("t1_tmo",    32'(tmo_a),    32'h0);
    check("t1_cycles", cyc_a,         32'd9);
    run_to(12);
    check("t1_frozen_cycles", cyc_a, 32'd9);

    // Fail-fast: ch1 reports code 0xA at edge 4, ch0 silent
    do_reset();
    do_start();
    run_to(3);
    exit_v[1] = 32'h15;
    run_to(4);
    check("t2_done",   32'(done_a),   32'h1);
    check("t2_pass",   32'(pass_a),   32'h0);
    check("t2_code",   32'(code_a),   32'hA);
    check("t2_idx",    32'(idx_a),    32'h1);
    check("t2_exited", 32'(exited_a), 32'h2);
    check("t2_cycles", cyc_a,         32'd4);

    // No fail-fast: ch0 code 3 at edge 2, ch1 code 5 at edge 3, ch0 changes at edge 6
    do_reset();
    do_start();
    run_to(1);
    exit_v[0] = 32'h7;
    run_to(2);
    check("t3_e2_done", 32'(done_b), 32'h0);
    check("t3_e2_code", 32'(code_b), 32'h3);
    exit_v[1] = 32'hB;
    run_to(3);
    check("t3_done",   32'(done_b),   32'h1);
    check("t3_code",   32'(code_b),   32'h3);
    check("t3_idx",    32'(idx_b),    32'h0);
    check("t3_exited", 32'(exited_b), 32'h3);
    check("t3_pass",   32'(pass_b),   32'h0);
    run_to(5);
    exit_v[0] = 32'h1;
    run_to(6);
    check("t3_late_code",   32'(code_b), 32'h3);
    check("t3_late_cycles", cyc_b,       32'd3);

    // Watchdog T=10 with no exits
    do_reset();
    do_start();
    run_to(9);
    check("t4_e9_done", 32'(done_b), 32'h0);
    run_to(10);
    check("t4_done",   32'(done_b), 32'h1);
    check("t4_tmo",    32'(tmo_b),  32'h1);
    check("t4_pass",   32'(pass_b), 32'h0);
    check("t4_cycles", cyc_b,       32'd10);

    // Completion at the watchdog edge wins
    do_reset();
    do_start();
    run_to(9);
    exit_v[0] = 32'h1;
    exit_v[1] = 32'h1;
    run_to(10);
    check("t4b_done",   32'(done_b), 32'h1);
    check("t4b_pass",   32'(pass_b), 32'h1);
    check("t4b_tmo",    32'(tmo_b),  32'h0);
    check("t4b_cycles", cyc_b,       32'd10);

    // First-exit mode; exits in IDLE and at the start edge are ignored
    do_reset();
    exit_v[0] = 32'h3;
    exit_v[1] = 32'h1;
    run_to(3);
    check("t5_idle_exited", 32'(exited_c), 32'h0);
    check("t5_idle_done",   32'(done_c),   32'h0);
    check("t5_idle_cycles", cyc_c,         32'h0);
    do_start();
    exit_v = '0;
    check("t5_start_exited", 32'(exited_c), 32'h0);
    run_to(6);
    exit_v[1] = 32'h1;
    run_to(7);
    check("t5_done",   32'(done_c),   32'h1);
    check("t5_pass",   32'(pass_c),   32'h1);
    check("t5_exited", 32'(exited_c), 32'h2);
    check("t5_cycles", cyc_c,         32'd7);

    // Reset dropped mid-run clears everything without a clock edge
    do_reset();
    do_start();
    run_to(1);
    exit_v[0] = 32'h7;
    run_to(3);
    check("t6_pre_done",   32'(done_a), 32'h1);
    check("t6_pre_cycles", cyc_a,       32'd2);
    rst = 1'b0;
    #1;
    check("t6_rst_exited", 32'(exited_a), 32'h0);
    check("t6_rst_done",   32'(done_a),   32'h0);
    check("t6_rst_code",   32'(code_a),   32'h0);
    check("t6_rst_cycles", cyc_a,         32'h0);

    // Fresh restart, both channels pass at the first RUN edge
    do_reset();
    do_start();
    exit_v[0] = 32'h1;
    exit_v[1] = 32'h1;
    run_to(1);
    check("t7_done",   32'(done_a),   32'h1);
    check("t7_pass",   32'(pass_a),   32'h1);
    check("t7_exited", 32'(exited_a), 32'h3);
    check("t7_cycles", cyc_a,         32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
